// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the tile-based character logic.
//   - Screen geometry: visible-area origin, tile pitch, tile-centre offset,
//     grid dimensions.
//   - Direction bit indices used on every 4-bit {left,down,up,right} vector.
//   - Movement FSM state encoding.
//   - tile_to_pixel(): grid (col,row) -> display pixel of that tile's centre.
//     map_index_to_display uses the same helper.
// ----------------------------------------------------------------------------
package game_pkg;

  localparam int unsigned ORIGIN_X   = 336;
  localparam int unsigned ORIGIN_Y   = 27;
  localparam int unsigned CENTER_OFF = 7;
  localparam int unsigned TILE_SIZE  = 16;
  localparam int unsigned GRID_W     = 80;
  localparam int unsigned GRID_H     = 30;

  localparam int unsigned POS_X_W = 11;
  localparam int unsigned POS_Y_W = 10;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 5;

  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_UP    = 1;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 3;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_MOVE   = 2'd2
  } move_state_e;

  typedef struct packed {
    logic [POS_X_W-1:0] x;
    logic [POS_Y_W-1:0] y;
  } pixel_t;

  // Centre pixel of tile (col,row). Unsigned; the largest grid index stays
  // well inside the output widths, so no overflow is possible.
  function automatic pixel_t tile_to_pixel(input logic [COL_W-1:0] col,
                                           input logic [ROW_W-1:0] row);
    pixel_t p;
    p.x = POS_X_W'(ORIGIN_X + CENTER_OFF) + POS_X_W'(col) * POS_X_W'(TILE_SIZE);
    p.y = POS_Y_W'(ORIGIN_Y + CENTER_OFF) + POS_Y_W'(row) * POS_Y_W'(TILE_SIZE);
    return p;
  endfunction

endpackage

// File: rtl/dir_priority_arbiter.sv
// ----------------------------------------------------------------------------
// dir_priority_arbiter
//   Masks the direction requests with the permitted moves and grants exactly
//   one of them, priority right > up > down > left.
//   Ports:
//     req_i        in  4  {left,down,up,right} requests (may be multi-hot)
//     valid_i      in  4  {left,down,up,right} permitted moves
//     grant_o      out 4  one-hot grant (all zero when nothing is granted)
//     any_grant_o  out 1  at least one request is permitted
// ----------------------------------------------------------------------------
module dir_priority_arbiter
  import game_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [3:0] valid_i,
  output logic [3:0] grant_o,
  output logic       any_grant_o
);

  logic [3:0] cand;

  assign cand        = req_i & valid_i;
  assign any_grant_o = |cand;

  always_comb begin
    grant_o = '0;
    if (cand[DIR_RIGHT])     grant_o[DIR_RIGHT] = 1'b1;
    else if (cand[DIR_UP])   grant_o[DIR_UP]    = 1'b1;
    else if (cand[DIR_DOWN]) grant_o[DIR_DOWN]  = 1'b1;
    else if (cand[DIR_LEFT]) grant_o[DIR_LEFT]  = 1'b1;
  end

endmodule

// File: rtl/character_move_controller.sv
// ----------------------------------------------------------------------------
// character_move_controller
//   Owns the character's display position. In IDLE it takes one direction
//   from the held requests that the valid_move_detector allows, updates the
//   grid index to the destination tile at once, then walks the display
//   position one pixel per frame_tick until it lands on the destination
//   centre. After every move (and after reset) it waits two clocks so the
//   detector's registered valid_moves reflects the new position.
//
//   Ports:
//     clk          in  1   system clock
//     rst_n        in  1   asynchronous active-low reset
//     frame_tick   in  1   one pulse per video frame; pixel step enable
//     dir_req      in  4   {left,down,up,right} level requests
//     valid_moves  in  4   {left,down,up,right} from valid_move_detector
//     curr_pos_x   out 11  character display X, pixels
//     curr_pos_y   out 10  character display Y, pixels
//     grid_col     out 7   current/destination column
//     grid_row     out 5   current/destination row
//     moving       out 1   high while a move is in progress
//
//   Build option WRAP_GATEWAY_EN: when defined, moving right off the last
//   column or left off column 0 is allowed (if valid_moves permits) and is
//   carried out as a single jump to the opposite edge on the first tick.
//   When undefined, both side edges are hard walls.
// ----------------------------------------------------------------------------
module character_move_controller
  import game_pkg::*;
#(
  parameter int unsigned START_COL = 1,
  parameter int unsigned START_ROW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [3:0]         dir_req,
  input  logic [3:0]         valid_moves,
  output logic [POS_X_W-1:0] curr_pos_x,
  output logic [POS_Y_W-1:0] curr_pos_y,
  output logic [COL_W-1:0]   grid_col,
  output logic [ROW_W-1:0]   grid_row,
  output logic               moving
);

`ifdef WRAP_GATEWAY_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [COL_W-1:0] COL_MAX     = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX     = ROW_W'(GRID_H - 1);
  localparam logic [4:0]       LAST_STEP   = 5'(TILE_SIZE - 1);
  localparam logic [4:0]       SETTLE_LAST = 5'd1;
  localparam pixel_t           START_PIX   =
    tile_to_pixel(COL_W'(START_COL), ROW_W'(START_ROW));

  move_state_e        state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;      // settle clocks or pixel steps taken
  logic [3:0]         dir_q, dir_d;      // one-hot direction of the current move
  logic               wrap_q, wrap_d;    // current move is an edge-to-edge jump
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [POS_X_W-1:0] x_q, x_d;
  logic [POS_Y_W-1:0] y_q, y_d;

  logic [3:0]         edge_ok;
  logic [3:0]         grant;
  logic               any_grant;
  pixel_t             dest_pix;

  // Grid-edge blocking applies even when the detector reports a move as
  // valid; the side edges open up only in the wrap build.
  always_comb begin
    edge_ok = 4'b1111;
    if (row_q == '0)                 edge_ok[DIR_UP]    = 1'b0;
    if (row_q == ROW_MAX)            edge_ok[DIR_DOWN]  = 1'b0;
    if (!WRAP_EN && col_q == '0)     edge_ok[DIR_LEFT]  = 1'b0;
    if (!WRAP_EN && col_q == COL_MAX) edge_ok[DIR_RIGHT] = 1'b0;
  end

  dir_priority_arbiter u_arb (
    .req_i       (dir_req),
    .valid_i     (valid_moves & edge_ok),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  // During MOVE col/row already hold the destination tile.
  assign dest_pix = tile_to_pixel(col_q, row_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_IDLE: begin
        // A tick coinciding with the grant is deliberately not a step.
        if (any_grant) begin
          state_d = ST_MOVE;
          dir_d   = grant;
          cnt_d   = '0;
          wrap_d  = 1'b0;
          if (grant[DIR_RIGHT]) begin
            if (col_q == COL_MAX) begin
              col_d  = '0;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (grant[DIR_UP]) begin
            row_d = row_q - ROW_W'(1);
          end else if (grant[DIR_DOWN]) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            if (col_q == '0) begin
              col_d  = COL_MAX;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q - COL_W'(1);
            end
          end
        end
      end

      ST_MOVE: begin
        if (frame_tick) begin
          if (wrap_q) begin
            x_d     = dest_pix.x;
            y_d     = dest_pix.y;
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            if (dir_q[DIR_RIGHT])     x_d = x_q + POS_X_W'(1);
            else if (dir_q[DIR_LEFT]) x_d = x_q - POS_X_W'(1);
            else if (dir_q[DIR_DOWN]) y_d = y_q + POS_Y_W'(1);
            else                      y_d = y_q - POS_Y_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_d = ST_SETTLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end

      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      wrap_q  <= 1'b0;
      col_q   <= COL_W'(START_COL);
      row_q   <= ROW_W'(START_ROW);
      x_q     <= START_PIX.x;
      y_q     <= START_PIX.y;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign curr_pos_x = x_q;
  assign curr_pos_y = y_q;
  assign grid_col   = col_q;
  assign grid_row   = row_q;
  assign moving     = (state_q == ST_MOVE);

endmodule

// File: tb/tb_character_move_controller.sv
module tb_character_move_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  dir_req;
  logic [3:0]  valid_moves;
  logic [10:0] curr_pos_x;
  logic [9:0]  curr_pos_y;
  logic [6:0]  grid_col;
  logic [4:0]  grid_row;
  logic        moving;

  character_move_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .dir_req     (dir_req),
    .valid_moves (valid_moves),
    .curr_pos_x  (curr_pos_x),
    .curr_pos_y  (curr_pos_y),
    .grid_col    (grid_col),
    .grid_row    (grid_row),
    .moving      (moving)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tile position, pixel position, and how much of the
  // current move / post-move wait remains.
  int m_col, m_row, m_x, m_y;
  int m_settle;   // clocks still to wait before requests are accepted
  int m_ticks;    // frame ticks still needed to finish the move
  int m_dx, m_dy;
  bit m_jump;

  function automatic int cx(int c); return 336 + 7 + c * 16; endfunction
  function automatic int cy(int r); return 27 + 7 + r * 16; endfunction
  function automatic int dcol(int d); return (d == 0) ? 1 : (d == 3) ? -1 : 0; endfunction
  function automatic int drow(int d); return (d == 1) ? -1 : (d == 2) ? 1 : 0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = 1; m_row = 1; m_x = cx(1); m_y = cy(1);
    m_settle = 2; m_ticks = 0; m_dx = 0; m_dy = 0; m_jump = 0;
  endtask

  task automatic model_clock(input bit tick, input logic [3:0] req, input logic [3:0] vld);
    bit taken;
    int nc, nr;
    bit wrap;
    if (m_ticks > 0) begin
      if (tick) begin
        if (m_jump) begin
          m_x = cx(m_col); m_y = cy(m_row); m_ticks = 0;
        end else begin
          m_x += m_dx; m_y += m_dy; m_ticks--;
        end
        if (m_ticks == 0) m_settle = 2;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      taken = 0;
      for (int d = 0; d < 4; d++) begin
        if (!taken && req[d] && vld[d]) begin
          nc = m_col + dcol(d);
          nr = m_row + drow(d);
          wrap = 0;
          if (nr >= 0 && nr < 30) begin
            if (nc < 0 || nc >= 80) begin
`ifdef WRAP_GATEWAY_EN
              wrap = 1;
              nc = (nc < 0) ? 79 : 0;
`else
              nc = -1;
`endif
            end
            if (nc >= 0) begin
              taken = 1;
              m_col = nc; m_row = nr;
              m_dx = dcol(d); m_dy = drow(d);
              m_jump = wrap;
              m_ticks = wrap ? 1 : 16;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("pos_x", curr_pos_x, m_x);
    chk("pos_y", curr_pos_y, m_y);
    chk("col", grid_col, m_col);
    chk("row", grid_row, m_row);
    chk("moving", moving, (m_ticks > 0));
  endtask

  // Called at a negedge; returns at the next negedge after checking.
  task automatic step(input bit tick, input logic [3:0] req, input logic [3:0] vld);
    frame_tick = tick; dir_req = req; valid_moves = vld;
    @(posedge clk);
    model_clock(tick, req, vld);
    @(negedge clk);
    compare_all();
  endtask

  task automatic finish_move();
    int budget = 200;
    while ((m_ticks > 0 || m_settle > 0) && budget > 0) begin
      step(1'b1, 4'b0000, 4'b0000);
      budget--;
    end
    chk("finish_budget", (budget > 0), 1);
  endtask

  task automatic goto(input int tc, input int tr);
    int budget = 20000;
    logic [3:0] r;
    while (!(m_col == tc && m_row == tr && m_ticks == 0 && m_settle == 0) && budget > 0) begin
      r = 4'b0000;
      if (m_col < tc)      r[0] = 1'b1;
      else if (m_col > tc) r[3] = 1'b1;
      else if (m_row < tr) r[2] = 1'b1;
      else if (m_row > tr) r[1] = 1'b1;
      step(1'b1, r, 4'b1111);
      budget--;
    end
    chk("goto_budget", (budget > 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rq;
    int c0, r0;

    rst_n = 1'b0; frame_tick = 1'b0; dir_req = 4'b0; valid_moves = 4'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    compare_all();
    chk("reset_x", curr_pos_x, 359);
    chk("reset_y", curr_pos_y, 50);

    // Move right from (7,7): one pixel per tick, reversal ignored.
    goto(7, 7);
    step(1'b1, 4'b0001, 4'b1111);
    chk("mr_col", grid_col, 8);
    chk("mr_x0", curr_pos_x, 455);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 4'b1000, 4'b1111);
      step(1'b1, 4'b1000, 4'b1111);
      chk("mr_x", curr_pos_x, 455 + i);
    end
    chk("mr_done_moving", moving, 0);
    step(1'b0, 4'b0000, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111);
    chk("mr_final_x", curr_pos_x, 471);

    // Blocked right, then left taken from the multi-hot request.
    for (int i = 0; i < 100; i++) step($urandom_range(0, 1), 4'b0001, 4'b1110);
    chk("blk_col", grid_col, 8);
    chk("blk_moving", moving, 0);
    step(1'b0, 4'b1001, 4'b1110);
    chk("blk_left_col", grid_col, 7);
    finish_move();

    // Priority.
    c0 = m_col;
    step(1'b0, 4'b1111, 4'b1101);
    chk("prio_right", grid_col, c0 + 1);
    finish_move();
    r0 = m_row;
    step(1'b0, 4'b0110, 4'b1111);
    chk("prio_up", grid_row, r0 - 1);
    finish_move();

    // Right edge at (79,25).
    goto(79, 25);
    chk("edge_x", curr_pos_x, 1607);
    chk("edge_y", curr_pos_y, 434);
`ifdef WRAP_GATEWAY_EN
    step(1'b1, 4'b0001, 4'b1111);
    chk("wrap_col", grid_col, 0);
    chk("wrap_x_pre", curr_pos_x, 1607);
    step(1'b1, 4'b0000, 4'b1111);
    chk("wrap_x", curr_pos_x, 343);
    chk("wrap_y", curr_pos_y, 434);
    finish_move();
`else
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0001, 4'b1111);
    chk("wall_col", grid_col, 79);
    chk("wall_moving", moving, 0);
`endif

    // Left edge.
    goto(0, 5);
    for (int i = 0; i < 30; i++) step($urandom_range(0, 1), 4'b1000, 4'b1111);
    finish_move();

    // Reset in the middle of a move.
    goto(10, 10);
    step(1'b0, 4'b0001, 4'b1111);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 4'b0000);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_x", curr_pos_x, 359);
    chk("rst_mid_y", curr_pos_y, 50);
    chk("rst_mid_moving", moving, 0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Random traffic.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 2) == 0), rq, 4'($urandom | $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
